// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: RSA modular exponentiation with an on-chip key store.
// Left-to-right square-and-multiply with a bit-serial Blakley modular multiplier.
// Optional define RSA_OPERAND_CHECK_EN: flags n==0, even n, or msg>=n as an error.
//
// state | meaning
// IDLE  | ready for a request; key writes allowed
// LOAD  | init acc and bit counter, detect trivial/invalid cases
// SCAN  | skip leading zero exponent bits, acc=b on first 1
// SQR   | acc = acc*acc mod n
// MUL   | acc = acc*b mod n
// DONE  | result presented until consumer accepts
module rsa_modexp_engine #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we_i,
  input  logic [1:0]       key_sel_i,
  input  logic [WIDTH-1:0] key_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_enc_i,
  input  logic [WIDTH-1:0] msg_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] msg_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CW = $clog2(EXP_WIDTH + 1);
  localparam int MW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, SQR, MUL, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     n_key_q;
  logic [EXP_WIDTH-1:0] e_key_q, d_key_q;
  logic [WIDTH-1:0]     b_q, b_d, n_q, n_d, acc_q, acc_d, p_q, p_d, mr_q, mr_d;
  logic [EXP_WIDTH-1:0] x_q, x_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [MW-1:0]        mm_cnt_q, mm_cnt_d;
  logic                 mm_clr_q, mm_clr_d;
  logic [WIDTH+1:0]     n_ext, mcand_ext, mm_t, mm_s;
  logic                 unused_mm_hi;

  // Key store: writable only while idle, survives reset.
  always_ff @(posedge clk) begin
    if (key_we_i && state_q == IDLE) begin
      case (key_sel_i)
        2'd0:    n_key_q <= key_i;
        2'd1:    e_key_q <= key_i[EXP_WIDTH-1:0];
        2'd2:    d_key_q <= key_i[EXP_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // One Blakley iteration: p = 2p mod n, then + multiplicand if multiplier bit set, mod n.
  always_comb begin
    n_ext     = {2'b00, n_q};
    mcand_ext = {2'b00, (state_q == MUL) ? b_q : acc_q};
    mm_t      = {1'b0, p_q, 1'b0};
    if (mm_t >= n_ext) mm_t = mm_t - n_ext;
    mm_s = mm_t + (mr_q[WIDTH-1] ? mcand_ext : '0);
    if (mm_s >= n_ext) mm_s = mm_s - n_ext;
  end

  assign unused_mm_hi = ^mm_s[WIDTH+1:WIDTH];

`ifdef RSA_OPERAND_CHECK_EN
  logic err_q, err_d;
`endif

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    n_d      = n_q;
    x_d      = x_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    mr_d     = mr_q;
    mm_cnt_d = mm_cnt_q;
    mm_clr_d = mm_clr_q;
`ifdef RSA_OPERAND_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i && !rst) begin
          b_d     = msg_i;
          x_d     = req_enc_i ? e_key_q : d_key_q;
          n_d     = n_key_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Early exits park cnt at 0 so SCAN falls straight through to DONE.
        acc_d   = ONE;
        cnt_d   = CW'(EXP_WIDTH);
        state_d = SCAN;
`ifdef RSA_OPERAND_CHECK_EN
        err_d   = 1'b0;
`endif
        if (x_q == '0) begin
          acc_d = (n_q == ONE) ? '0 : ONE;
          cnt_d = '0;
        end
`ifdef RSA_OPERAND_CHECK_EN
        if (n_q == '0 || !n_q[0] || b_q >= n_q) begin
          err_d = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end
`endif
      end
      SCAN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          x_d   = x_q << 1;
          cnt_d = cnt_q - 1'b1;
          if (x_q[EXP_WIDTH-1]) begin
            acc_d    = b_q;
            mm_clr_d = 1'b1;
            state_d  = (cnt_q == CW'(1)) ? DONE : SQR;
          end
        end
      end
      SQR, MUL: begin
        if (mm_clr_q) begin
          p_d      = '0;
          mr_d     = acc_q;
          mm_cnt_d = MW'(WIDTH);
          mm_clr_d = 1'b0;
        end else begin
          p_d      = mm_s[WIDTH-1:0];
          mr_d     = mr_q << 1;
          mm_cnt_d = mm_cnt_q - 1'b1;
          if (mm_cnt_q == MW'(1)) begin
            acc_d    = mm_s[WIDTH-1:0];
            mm_clr_d = 1'b1;
            // After a square, a set next bit needs a multiply before it is consumed.
            if (state_q == SQR && x_q[EXP_WIDTH-1]) begin
              state_d = MUL;
            end else begin
              x_d     = x_q << 1;
              cnt_d   = cnt_q - 1'b1;
              state_d = (cnt_q == CW'(1)) ? DONE : SQR;
            end
          end
        end
      end
      DONE: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mm_clr_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mm_clr_q <= mm_clr_d;
    end
  end

  // Datapath registers; contents are only meaningful while an operation is running.
  always_ff @(posedge clk) begin
    b_q      <= b_d;
    n_q      <= n_d;
    x_q      <= x_d;
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
    p_q      <= p_d;
    mr_q     <= mr_d;
    mm_cnt_q <= mm_cnt_d;
  end

`ifdef RSA_OPERAND_CHECK_EN
  // Error flag for the operand check.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_o = (state_q == DONE) && err_q;
`else
  assign err_o = 1'b0;
`endif

  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign resp_valid_o = (state_q == DONE);
  assign msg_o        = (state_q == DONE) ? acc_q : '0;
  assign busy_o       = (state_q != IDLE);

endmodule
